// File: rtl/arith_unit_pkg.sv
// arith_unit_pkg
//   Shared constants, the register word type and helpers for the arithmetic
//   unit. Bit 0 of every register word is the MSB/sign and bit 30 is the
//   LSB, so words are declared with an ascending range [0:AU_W-1]. With that
//   range a numeric left shift moves data toward bit 0.
//   Optional feature macro used by this slice: AU_CONFLICT_CHECK_EN.
package arith_unit_pkg;

   localparam int AU_W    = 31;   // register width
   localparam int AU_SIGN = 0;    // index of the MSB/sign bit
   localparam int AU_LSB  = 30;   // index of the LSB

   typedef logic [0:AU_W-1] au_word_t;

   localparam au_word_t AU_ZERO = {AU_W{1'b0}};

   // Writer classes that can target a register in one cycle, in priority order.
   typedef enum logic [2:0] {
      CLS_CLEAR = 3'd0,
      CLS_MOVE  = 3'd1,
      CLS_NOT   = 3'd2,
      CLS_ARITH = 3'd3,
      CLS_SHIFT = 3'd4
   } au_class_e;

   // True when more than one bit of a writer-class vector is set.
   function automatic logic multi_hot(input logic [4:0] v);
      return ((v & (v - 5'd1)) != 5'd0);
   endfunction

endpackage

// File: rtl/au_adder.sv
// au_adder
//   31-bit unsigned adder for the arithmetic unit. Purely combinational.
//   Ports:
//     a, b       in  31  operands (bit 0 = MSB)
//     sum        out 31  a + b with the carry discarded
//     carry_out  out 1   carry out of bit 0 (the MSB)
module au_adder
   import arith_unit_pkg::*;
(
   input  logic [0:AU_W-1] a,
   input  logic [0:AU_W-1] b,
   output logic [0:AU_W-1] sum,
   output logic            carry_out
);

   logic [AU_W:0] full_s;

   // One extra bit on the left captures the carry out of the MSB.
   assign full_s    = {1'b0, a} + {1'b0, b};
   assign sum       = full_s[AU_W-1:0];
   assign carry_out = full_s[AU_W];

endmodule

// File: rtl/arith_unit.sv
// arith_unit
//   Three 31-bit working registers A, B, C driven by single-cycle command
//   pulses (clear, invert, add, and, shifts, moves, memory load). All writers
//   of a register are resolved by priority: clear > load/move > not >
//   sum/and > shift; do_set_c_30 ORs into C after that resolution. Every
//   operation samples pre-edge register values, so coupled shifts and
//   register swaps in one cycle are well defined.
//   Ports:
//     clk, resetn                  clock, asynchronous active-low reset
//     do_*_to_au, load_a_from_mem  command pulses
//     do_left_shift_c29_to_au      qualifier: hold C bit 0 on a C left shift,
//                                  and fill B bit 30 from C bit 1
//     mem_data_from_mem            word loaded into A
//     carry_out_from_au            combinational carry of A + B
//     reg_c_30_from_au, reg_b_0_from_au, reg_c_to_mem   register contents
//     au_error                     sticky writer-conflict flag
//   Macro AU_CONFLICT_CHECK_EN enables the conflict check; without it
//   au_error is tied low.
module arith_unit
   import arith_unit_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   input  logic            do_clear_a_to_au,
   input  logic            do_clear_b_to_au,
   input  logic            do_clear_c_to_au,
   input  logic            do_not_a_to_au,
   input  logic            do_not_b_to_au,
   input  logic            do_sum_to_au,
   input  logic            do_and_to_au,
   input  logic            do_set_c_30_to_au,
   input  logic            do_left_shift_b_to_au,
   input  logic            do_left_shift_c_to_au,
   input  logic            do_left_shift_c29_to_au,
   input  logic            do_right_shift_bc_to_au,
   input  logic            do_move_c_to_a_to_au,
   input  logic            do_move_c_to_b_to_au,
   input  logic            do_move_b_to_c_to_au,
   input  logic            load_a_from_mem,
   input  logic [0:AU_W-1] mem_data_from_mem,
   output logic            carry_out_from_au,
   output logic            reg_c_30_from_au,
   output logic            reg_b_0_from_au,
   output logic [0:AU_W-1] reg_c_to_mem,
   output logic            au_error
);

   au_word_t a_r, b_r, c_r;
   au_word_t a_nxt_s, b_nxt_s, c_pri_s, c_nxt_s;
   au_word_t sum_s;
   au_word_t b_shl_s, b_shr_s, c_shl_s, c_shr_s;
   logic     b_fill_s;

   au_adder u_adder (
      .a         (a_r),
      .b         (b_r),
      .sum       (sum_s),
      .carry_out (carry_out_from_au)
   );

   // Shift candidates, all built from pre-edge values so B and C can shift together.
   always_comb begin
      b_fill_s = do_left_shift_c29_to_au ? c_r[1] : c_r[AU_SIGN];
      b_shl_s  = {b_r[1:AU_LSB], b_fill_s};
      b_shr_s  = {1'b0, b_r[AU_SIGN:AU_LSB-1]};
      c_shr_s  = {b_r[AU_LSB], c_r[AU_SIGN:AU_LSB-1]};
      if (do_left_shift_c29_to_au) begin
         c_shl_s = {c_r[AU_SIGN], c_r[2:AU_LSB], 1'b0};
      end else begin
         c_shl_s = {c_r[1:AU_LSB], 1'b0};
      end
   end

   // Next value of A by writer priority.
   always_comb begin
      a_nxt_s = a_r;
      if (do_clear_a_to_au) begin
         a_nxt_s = AU_ZERO;
      end else if (load_a_from_mem) begin
         a_nxt_s = mem_data_from_mem;
      end else if (do_move_c_to_a_to_au) begin
         a_nxt_s = c_r;
      end else if (do_not_a_to_au) begin
         a_nxt_s = ~a_r;
      end else begin
         a_nxt_s = a_r;
      end
   end

   // Next value of B by writer priority.
   always_comb begin
      b_nxt_s = b_r;
      if (do_clear_b_to_au) begin
         b_nxt_s = AU_ZERO;
      end else if (do_move_c_to_b_to_au) begin
         b_nxt_s = c_r;
      end else if (do_not_b_to_au) begin
         b_nxt_s = ~b_r;
      end else if (do_sum_to_au) begin
         b_nxt_s = sum_s;
      end else if (do_left_shift_b_to_au) begin
         b_nxt_s = b_shl_s;
      end else if (do_right_shift_bc_to_au) begin
         b_nxt_s = b_shr_s;
      end else begin
         b_nxt_s = b_r;
      end
   end

   // Next value of C by writer priority, then the bit-30 set ORed on top.
   always_comb begin
      c_pri_s = c_r;
      if (do_clear_c_to_au) begin
         c_pri_s = AU_ZERO;
      end else if (do_move_b_to_c_to_au) begin
         c_pri_s = b_r;
      end else if (do_and_to_au) begin
         c_pri_s = a_r & b_r;
      end else if (do_left_shift_c_to_au) begin
         c_pri_s = c_shl_s;
      end else if (do_right_shift_bc_to_au) begin
         c_pri_s = c_shr_s;
      end else begin
         c_pri_s = c_r;
      end
      c_nxt_s         = c_pri_s;
      c_nxt_s[AU_LSB] = c_pri_s[AU_LSB] | do_set_c_30_to_au;
   end

   // Working registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         a_r <= AU_ZERO;
         b_r <= AU_ZERO;
         c_r <= AU_ZERO;
      end else begin
         a_r <= a_nxt_s;
         b_r <= b_nxt_s;
         c_r <= c_nxt_s;
      end
   end

   assign reg_c_30_from_au = c_r[AU_LSB];
   assign reg_b_0_from_au  = b_r[AU_SIGN];
   assign reg_c_to_mem     = c_r;

`ifdef AU_CONFLICT_CHECK_EN
   logic [4:0] a_cls_s, b_cls_s, c_cls_s;
   logic       conflict_s;
   logic       err_r;

   // One bit per writer class that targets each register this cycle.
   always_comb begin
      a_cls_s = 5'd0;
      b_cls_s = 5'd0;
      c_cls_s = 5'd0;
      a_cls_s[CLS_CLEAR] = do_clear_a_to_au;
      a_cls_s[CLS_MOVE]  = load_a_from_mem | do_move_c_to_a_to_au;
      a_cls_s[CLS_NOT]   = do_not_a_to_au;
      b_cls_s[CLS_CLEAR] = do_clear_b_to_au;
      b_cls_s[CLS_MOVE]  = do_move_c_to_b_to_au;
      b_cls_s[CLS_NOT]   = do_not_b_to_au;
      b_cls_s[CLS_ARITH] = do_sum_to_au;
      b_cls_s[CLS_SHIFT] = do_left_shift_b_to_au | do_right_shift_bc_to_au;
      c_cls_s[CLS_CLEAR] = do_clear_c_to_au;
      c_cls_s[CLS_MOVE]  = do_move_b_to_c_to_au;
      c_cls_s[CLS_ARITH] = do_and_to_au;
      c_cls_s[CLS_SHIFT] = do_left_shift_c_to_au | do_right_shift_bc_to_au;
      conflict_s = multi_hot(a_cls_s) | multi_hot(b_cls_s) | multi_hot(c_cls_s);
   end

   // Sticky conflict flag, cleared only by reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r | conflict_s;
      end
   end

   assign au_error = err_r;
`else
   assign au_error = 1'b0;
`endif

endmodule

// File: tb/tb_arith_unit.sv
// tb_arith_unit
//   Directed-vector bench for arith_unit. Registers are preloaded through the
//   memory load / sum / move path, and B is observed by moving it into C.
module tb_arith_unit;

   logic        clk;
   logic        resetn;
   logic        do_clear_a_to_au, do_clear_b_to_au, do_clear_c_to_au;
   logic        do_not_a_to_au, do_not_b_to_au;
   logic        do_sum_to_au, do_and_to_au, do_set_c_30_to_au;
   logic        do_left_shift_b_to_au, do_left_shift_c_to_au, do_left_shift_c29_to_au;
   logic        do_right_shift_bc_to_au;
   logic        do_move_c_to_a_to_au, do_move_c_to_b_to_au, do_move_b_to_c_to_au;
   logic        load_a_from_mem;
   logic [30:0] mem_data_from_mem;
   logic        carry_out_from_au;
   logic        reg_c_30_from_au, reg_b_0_from_au;
   logic [30:0] reg_c_to_mem;
   logic        au_error;

   int vec_cnt = 0;
   int err_cnt = 0;
   logic exp_err;

   arith_unit dut (
      .clk                     (clk),
      .resetn                  (resetn),
      .do_clear_a_to_au        (do_clear_a_to_au),
      .do_clear_b_to_au        (do_clear_b_to_au),
      .do_clear_c_to_au        (do_clear_c_to_au),
      .do_not_a_to_au          (do_not_a_to_au),
      .do_not_b_to_au          (do_not_b_to_au),
      .do_sum_to_au            (do_sum_to_au),
      .do_and_to_au            (do_and_to_au),
      .do_set_c_30_to_au       (do_set_c_30_to_au),
      .do_left_shift_b_to_au   (do_left_shift_b_to_au),
      .do_left_shift_c_to_au   (do_left_shift_c_to_au),
      .do_left_shift_c29_to_au (do_left_shift_c29_to_au),
      .do_right_shift_bc_to_au (do_right_shift_bc_to_au),
      .do_move_c_to_a_to_au    (do_move_c_to_a_to_au),
      .do_move_c_to_b_to_au    (do_move_c_to_b_to_au),
      .do_move_b_to_c_to_au    (do_move_b_to_c_to_au),
      .load_a_from_mem         (load_a_from_mem),
      .mem_data_from_mem       (mem_data_from_mem),
      .carry_out_from_au       (carry_out_from_au),
      .reg_c_30_from_au        (reg_c_30_from_au),
      .reg_b_0_from_au         (reg_b_0_from_au),
      .reg_c_to_mem            (reg_c_to_mem),
      .au_error                (au_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_all();
      do_clear_a_to_au = 1'b0; do_clear_b_to_au = 1'b0; do_clear_c_to_au = 1'b0;
      do_not_a_to_au = 1'b0; do_not_b_to_au = 1'b0;
      do_sum_to_au = 1'b0; do_and_to_au = 1'b0; do_set_c_30_to_au = 1'b0;
      do_left_shift_b_to_au = 1'b0; do_left_shift_c_to_au = 1'b0;
      do_left_shift_c29_to_au = 1'b0; do_right_shift_bc_to_au = 1'b0;
      do_move_c_to_a_to_au = 1'b0; do_move_c_to_b_to_au = 1'b0;
      do_move_b_to_c_to_au = 1'b0; load_a_from_mem = 1'b0;
      mem_data_from_mem = 31'h0;
   endtask

   // Apply the currently driven pulses at one rising edge, then drop them.
   task automatic step();
      @(posedge clk);
      #1;
      clear_all();
   endtask

   // Preload A, B, C without any same-register writer conflicts.
   task automatic set_regs(input logic [30:0] av, input logic [30:0] bv, input logic [30:0] cv);
      mem_data_from_mem = cv; load_a_from_mem = 1'b1;
      do_clear_b_to_au = 1'b1; do_clear_c_to_au = 1'b1;
      step();
      do_sum_to_au = 1'b1;
      step();
      mem_data_from_mem = bv; load_a_from_mem = 1'b1;
      do_move_b_to_c_to_au = 1'b1; do_clear_b_to_au = 1'b1;
      step();
      mem_data_from_mem = av; load_a_from_mem = 1'b1; do_sum_to_au = 1'b1;
      step();
   endtask

   task automatic move_b_to_c();
      do_move_b_to_c_to_au = 1'b1;
      step();
   endtask

   task automatic test_reset();
      clear_all();
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vec_cnt++; if (reg_c_to_mem !== 31'h0) begin err_cnt++; $display("FAIL reset_c: got %h want %h", reg_c_to_mem, 31'h0); end
      vec_cnt++; if (reg_c_30_from_au !== 1'b0) begin err_cnt++; $display("FAIL reset_c30: got %b want 0", reg_c_30_from_au); end
      vec_cnt++; if (reg_b_0_from_au !== 1'b0) begin err_cnt++; $display("FAIL reset_b0: got %b want 0", reg_b_0_from_au); end
      vec_cnt++; if (carry_out_from_au !== 1'b0) begin err_cnt++; $display("FAIL reset_carry: got %b want 0", carry_out_from_au); end
      vec_cnt++; if (au_error !== 1'b0) begin err_cnt++; $display("FAIL reset_err: got %b want 0", au_error); end
      resetn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_sum();
      set_regs(31'h00000001, 31'h7FFFFFFF, 31'h0);
      vec_cnt++; if (carry_out_from_au !== 1'b1) begin err_cnt++; $display("FAIL sum_carry_pre: got %b want 1", carry_out_from_au); end
      vec_cnt++; if (reg_b_0_from_au !== 1'b1) begin err_cnt++; $display("FAIL sum_b0_pre: got %b want 1", reg_b_0_from_au); end
      do_sum_to_au = 1'b1; step();
      vec_cnt++; if (carry_out_from_au !== 1'b0) begin err_cnt++; $display("FAIL sum_carry_post: got %b want 0", carry_out_from_au); end
      move_b_to_c();
      vec_cnt++; if (reg_c_to_mem !== 31'h0) begin err_cnt++; $display("FAIL sum_wrap: got %h want %h", reg_c_to_mem, 31'h0); end
      set_regs(31'h12345678, 31'h01010101, 31'h0);
      vec_cnt++; if (carry_out_from_au !== 1'b0) begin err_cnt++; $display("FAIL sum2_carry: got %b want 0", carry_out_from_au); end
      do_sum_to_au = 1'b1; step();
      move_b_to_c();
      vec_cnt++; if (reg_c_to_mem !== 31'h13355779) begin err_cnt++; $display("FAIL sum2: got %h want %h", reg_c_to_mem, 31'h13355779); end
   endtask

   task automatic test_sum_set_c30();
      set_regs(31'h3, 31'h4, 31'h0);
      do_sum_to_au = 1'b1; do_set_c_30_to_au = 1'b1; step();
      vec_cnt++; if (reg_c_30_from_au !== 1'b1) begin err_cnt++; $display("FAIL setc30_bit: got %b want 1", reg_c_30_from_au); end
      vec_cnt++; if (reg_c_to_mem !== 31'h1) begin err_cnt++; $display("FAIL setc30_c: got %h want %h", reg_c_to_mem, 31'h1); end
      move_b_to_c();
      vec_cnt++; if (reg_c_to_mem !== 31'h7) begin err_cnt++; $display("FAIL setc30_sum: got %h want %h", reg_c_to_mem, 31'h7); end
   endtask

   task automatic test_and_not();
      set_regs(31'h0F0F0F0F, 31'h00FF00FF, 31'h0);
      do_and_to_au = 1'b1; step();
      vec_cnt++; if (reg_c_to_mem !== 31'h000F000F) begin err_cnt++; $display("FAIL and: got %h want %h", reg_c_to_mem, 31'h000F000F); end
      do_not_b_to_au = 1'b1; step();
      move_b_to_c();
      vec_cnt++; if (reg_c_to_mem !== 31'h7F00FF00) begin err_cnt++; $display("FAIL not_b: got %h want %h", reg_c_to_mem, 31'h7F00FF00); end
   endtask

   task automatic test_right_shift();
      set_regs(31'h0, 31'h40000000, 31'h00000001);
      vec_cnt++; if (reg_c_30_from_au !== 1'b1) begin err_cnt++; $display("FAIL rsh_c30_pre: got %b want 1", reg_c_30_from_au); end
      do_right_shift_bc_to_au = 1'b1; step();
      vec_cnt++; if (reg_c_to_mem !== 31'h0) begin err_cnt++; $display("FAIL rsh_c: got %h want %h", reg_c_to_mem, 31'h0); end
      move_b_to_c();
      vec_cnt++; if (reg_c_to_mem !== 31'h20000000) begin err_cnt++; $display("FAIL rsh_b: got %h want %h", reg_c_to_mem, 31'h20000000); end
      // B bit 30 carries into C bit 0.
      set_regs(31'h0, 31'h00000003, 31'h00000000);
      do_right_shift_bc_to_au = 1'b1; step();
      vec_cnt++; if (reg_c_to_mem !== 31'h40000000) begin err_cnt++; $display("FAIL rsh_cross: got %h want %h", reg_c_to_mem, 31'h40000000); end
   endtask

   task automatic test_coupled_shift();
      set_regs(31'h0, 31'h0, 31'h60000000);
      do_left_shift_b_to_au = 1'b1; do_left_shift_c_to_au = 1'b1; do_left_shift_c29_to_au = 1'b1; step();
      vec_cnt++; if (reg_c_to_mem !== 31'h40000000) begin err_cnt++; $display("FAIL lsh29_c: got %h want %h", reg_c_to_mem, 31'h40000000); end
      move_b_to_c();
      vec_cnt++; if (reg_c_to_mem !== 31'h00000001) begin err_cnt++; $display("FAIL lsh29_b: got %h want %h", reg_c_to_mem, 31'h00000001); end
      set_regs(31'h0, 31'h00000002, 31'h40000001);
      do_left_shift_b_to_au = 1'b1; do_left_shift_c_to_au = 1'b1; step();
      vec_cnt++; if (reg_c_to_mem !== 31'h00000002) begin err_cnt++; $display("FAIL lsh_c: got %h want %h", reg_c_to_mem, 31'h00000002); end
      move_b_to_c();
      vec_cnt++; if (reg_c_to_mem !== 31'h00000005) begin err_cnt++; $display("FAIL lsh_b: got %h want %h", reg_c_to_mem, 31'h00000005); end
   endtask

   task automatic test_swap();
      set_regs(31'h0, 31'h11, 31'h22);
      do_move_b_to_c_to_au = 1'b1; do_move_c_to_b_to_au = 1'b1; step();
      vec_cnt++; if (reg_c_to_mem !== 31'h11) begin err_cnt++; $display("FAIL swap_c: got %h want %h", reg_c_to_mem, 31'h11); end
      move_b_to_c();
      vec_cnt++; if (reg_c_to_mem !== 31'h22) begin err_cnt++; $display("FAIL swap_b: got %h want %h", reg_c_to_mem, 31'h22); end
   endtask

   task automatic test_priority();
      // Clear outranks a load that lands on C via set-bit only; set still ORs in.
      set_regs(31'h0, 31'h0, 31'h12);
      do_clear_c_to_au = 1'b1; do_set_c_30_to_au = 1'b1; step();
      vec_cnt++; if (reg_c_to_mem !== 31'h1) begin err_cnt++; $display("FAIL prio_clr_set: got %h want %h", reg_c_to_mem, 31'h1); end
      vec_cnt++; if (au_error !== 1'b0) begin err_cnt++; $display("FAIL prio_err_none: got %b want 0", au_error); end
      set_regs(31'h5, 31'h9, 31'h0);
      do_clear_b_to_au = 1'b1; do_sum_to_au = 1'b1; step();
      move_b_to_c();
      vec_cnt++; if (reg_c_to_mem !== 31'h0) begin err_cnt++; $display("FAIL prio_clr_sum: got %h want %h", reg_c_to_mem, 31'h0); end
      vec_cnt++; if (au_error !== exp_err) begin err_cnt++; $display("FAIL prio_err_set: got %b want %b", au_error, exp_err); end
      repeat (3) step();
      vec_cnt++; if (au_error !== exp_err) begin err_cnt++; $display("FAIL prio_err_sticky: got %b want %b", au_error, exp_err); end
   endtask

   task automatic test_async_reset();
      set_regs(31'h1, 31'h2, 31'h3);
      #2;
      resetn = 1'b0;
      #1;
      vec_cnt++; if (reg_c_to_mem !== 31'h0) begin err_cnt++; $display("FAIL areset_c: got %h want %h", reg_c_to_mem, 31'h0); end
      vec_cnt++; if (au_error !== 1'b0) begin err_cnt++; $display("FAIL areset_err: got %b want 0", au_error); end
      vec_cnt++; if (carry_out_from_au !== 1'b0) begin err_cnt++; $display("FAIL areset_carry: got %b want 0", carry_out_from_au); end
      @(posedge clk);
      #1;
      resetn = 1'b1;
      do_not_b_to_au = 1'b1; step();
      move_b_to_c();
      vec_cnt++; if (reg_c_to_mem !== 31'h7FFFFFFF) begin err_cnt++; $display("FAIL areset_after: got %h want %h", reg_c_to_mem, 31'h7FFFFFFF); end
   endtask

   initial begin
`ifdef AU_CONFLICT_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      test_reset();
      test_sum();
      test_sum_set_c30();
      test_and_not();
      test_right_shift();
      test_coupled_shift();
      test_swap();
      test_priority();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
